// File: rtl/cond_logic_pkg.sv
// Shared definitions for the conditional-execution stage: condition codes,
// NZCV bit positions within the flag register, FlagW bit positions.
package cond_logic_pkg;

  // Instr[31:28] condition encodings
  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;  // unused encoding, never executes

  // Bit positions inside the {N,Z,C,V} vectors
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // FlagW bit positions: upper half writes N,Z, lower half writes C,V
  localparam int FLAGW_NZ = 1;
  localparam int FLAGW_CV = 0;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } nzcv_t;

  // Unpack a raw 4-bit flag vector using the named bit positions
  function automatic nzcv_t to_nzcv(input logic [3:0] f);
    nzcv_t r;
    r.n = f[FLAG_N];
    r.z = f[FLAG_Z];
    r.c = f[FLAG_C];
    r.v = f[FLAG_V];
    return r;
  endfunction

endpackage

// File: rtl/cond_logic_cond_check.sv
// cond_check: purely combinational condition evaluator.
// Compares the instruction Cond field against the registered NZCV flags.
module cond_check
  import cond_logic_pkg::*;
(
  input  logic [3:0] Cond,
  input  logic [3:0] Flags,
  output logic       CondEx
);

  nzcv_t f;
  logic  ge;

  assign f  = to_nzcv(Flags);
  assign ge = (f.n == f.v);

  // Condition table; the unused encoding resolves to 0 so CondEx is never X
  always_comb begin
    CondEx = 1'b0;
    case (Cond)
      COND_EQ: CondEx = f.z;
      COND_NE: CondEx = ~f.z;
      COND_CS: CondEx = f.c;
      COND_CC: CondEx = ~f.c;
      COND_MI: CondEx = f.n;
      COND_PL: CondEx = ~f.n;
      COND_VS: CondEx = f.v;
      COND_VC: CondEx = ~f.v;
      COND_HI: CondEx = f.c & ~f.z;
      COND_LS: CondEx = ~f.c | f.z;
      COND_GE: CondEx = ge;
      COND_LT: CondEx = ~ge;
      COND_GT: CondEx = ~f.z & ge;
      COND_LE: CondEx = f.z | ~ge;
      COND_AL: CondEx = 1'b1;
      default: CondEx = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_logic.sv
// cond_logic: conditional-execution stage behind the instruction decoder.
// Holds the NZCV flag register, gates the decoder write strobes with the
// condition result and the retire enable, and optionally counts
// executed/squashed retires (define CONDLOGIC_PERF_EN to build the counters).
module cond_logic
  import cond_logic_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [3:0]       Cond,
  input  logic [3:0]       ALUFlags,
  input  logic [1:0]       FlagW,
  input  logic             PCS,
  input  logic             RegW,
  input  logic             MemW,
  output logic             PCSrc,
  output logic             RegWrite,
  output logic             MemWrite,
  output logic             CondEx,
  output logic [3:0]       Flags,
  output logic [CNT_W-1:0] ExecCnt,
  output logic [CNT_W-1:0] SquashCnt
);

  logic retire_pass;
  logic wr_nz;
  logic wr_cv;

  // Condition is judged on the registered flags only; there is no bypass
  // from ALUFlags, so a flag write is seen by the following instruction.
  cond_check u_cond_check (
    .Cond   (Cond),
    .Flags  (Flags),
    .CondEx (CondEx)
  );

  assign retire_pass = en & CondEx;
  assign wr_nz       = retire_pass & FlagW[FLAGW_NZ];
  assign wr_cv       = retire_pass & FlagW[FLAGW_CV];

  assign PCSrc    = PCS  & retire_pass;
  assign RegWrite = RegW & retire_pass;
  assign MemWrite = MemW & retire_pass;

  // N,Z half of the flag register, written only by a passing retire
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      Flags[FLAG_N] <= 1'b0;
      Flags[FLAG_Z] <= 1'b0;
    end else if (wr_nz) begin
      Flags[FLAG_N] <= ALUFlags[FLAG_N];
      Flags[FLAG_Z] <= ALUFlags[FLAG_Z];
    end
  end

  // C,V half of the flag register, independent of the N,Z half
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      Flags[FLAG_C] <= 1'b0;
      Flags[FLAG_V] <= 1'b0;
    end else if (wr_cv) begin
      Flags[FLAG_C] <= ALUFlags[FLAG_C];
      Flags[FLAG_V] <= ALUFlags[FLAG_V];
    end
  end

`ifdef CONDLOGIC_PERF_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Exactly one counter moves per retire; both saturate instead of wrapping
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ExecCnt   <= '0;
      SquashCnt <= '0;
    end else if (en) begin
      if (CondEx) begin
        if (ExecCnt != CNT_MAX) ExecCnt <= ExecCnt + 1'b1;
      end else begin
        if (SquashCnt != CNT_MAX) SquashCnt <= SquashCnt + 1'b1;
      end
    end
  end
`else
  // Counters not built; ports kept so the same bench drives both builds
  assign ExecCnt   = '0;
  assign SquashCnt = '0;
`endif

endmodule

// File: tb/tb_cond_logic.sv
// Directed self-checking bench for cond_logic (built with CNT_W=4 so
// saturation is reachable; expectations follow CONDLOGIC_PERF_EN).
module tb_cond_logic;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          en;
  logic [3:0]    Cond;
  logic [3:0]    ALUFlags;
  logic [1:0]    FlagW;
  logic          PCS, RegW, MemW;
  logic          PCSrc, RegWrite, MemWrite, CondEx;
  logic [3:0]    Flags;
  logic [CW-1:0] ExecCnt, SquashCnt;

  int checks = 0;
  int errors = 0;

  cond_logic #(.CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .en(en), .Cond(Cond), .ALUFlags(ALUFlags),
    .FlagW(FlagW), .PCS(PCS), .RegW(RegW), .MemW(MemW),
    .PCSrc(PCSrc), .RegWrite(RegWrite), .MemWrite(MemWrite), .CondEx(CondEx),
    .Flags(Flags), .ExecCnt(ExecCnt), .SquashCnt(SquashCnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // inputs change 1 time unit after a rising edge, outputs are sampled 1 unit later
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference condition table written by condition pairs: base test for
  // Cond[3:1], inverted by Cond[0]; 1111 never passes.
  function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cc, v, b;
    n = f[3]; z = f[2]; cc = f[1]; v = f[0];
    case (c[3:1])
      3'd0: b = z;
      3'd1: b = cc;
      3'd2: b = n;
      3'd3: b = v;
      3'd4: b = cc && !z;
      3'd5: b = (n == v);
      3'd6: b = !z && (n == v);
      default: b = 1'b1;
    endcase
    if (c == 4'b1111) return 1'b0;
    return c[0] ? !b : b;
  endfunction

  // Load the flag register through an always-executing instruction
  task automatic load_flags(input logic [3:0] f);
    en = 1; Cond = 4'b1110; FlagW = 2'b11; ALUFlags = f;
    PCS = 0; RegW = 0; MemW = 0;
    tick();
    FlagW = 2'b00;
  endtask

  logic perf;
  logic [3:0] exp_e, exp_s;

  initial begin
`ifdef CONDLOGIC_PERF_EN
    perf = 1'b1;
`else
    perf = 1'b0;
`endif
    reset = 1; en = 0; Cond = 0; ALUFlags = 0; FlagW = 0; PCS = 0; RegW = 0; MemW = 0;
    #12;
    // reset state
    chk("rst_flags", Flags, 4'b0000);
    chk("rst_exec", ExecCnt, 0);
    chk("rst_squash", SquashCnt, 0);
    Cond = 4'b0000; #1;
    chk("rst_eq_fails", CondEx, 0);
    Cond = 4'b0001; #1;
    chk("rst_ne_passes", CondEx, 1);
    reset = 0;
    @(posedge clk); #1;

    // 1: AL passes, EQ fails on cleared flags
    en = 1; Cond = 4'b1110; RegW = 1; #1;
    chk("t1_al_regwrite", RegWrite, 1);
    chk("t1_flags", Flags, 4'b0000);
    Cond = 4'b0000; #1;
    chk("t1_eq_condex", CondEx, 0);
    chk("t1_eq_regwrite", RegWrite, 0);
    RegW = 0;

    // 2: flag write visible next cycle, not in the same cycle
    Cond = 4'b1110; FlagW = 2'b11; ALUFlags = 4'b0100; #1;
    Cond = 4'b0000; #1;
    chk("t2_same_cycle_eq", CondEx, 0);
    Cond = 4'b1110; #1;
    tick();
    FlagW = 2'b00; ALUFlags = 4'b0000; Cond = 4'b0000; PCS = 1; #1;
    chk("t2_flags", Flags, 4'b0100);
    chk("t2_eq_condex", CondEx, 1);
    chk("t2_pcsrc", PCSrc, 1);
    PCS = 0;

    // 3: independent halves
    load_flags(4'b1000);
    chk("t3_load", Flags, 4'b1000);
    FlagW = 2'b01; ALUFlags = 4'b0011; tick();
    chk("t3_cv_only", Flags, 4'b1011);
    FlagW = 2'b10; ALUFlags = 4'b0100; tick();
    chk("t3_nz_only", Flags, 4'b0111);
    FlagW = 2'b00;

    // 4: failed condition blocks flag and memory writes
    load_flags(4'b0000);
    Cond = 4'b0000; FlagW = 2'b11; ALUFlags = 4'b1111; MemW = 1; #1;
    chk("t4_memwrite", MemWrite, 0);
    tick();
    chk("t4_flags_hold", Flags, 4'b0000);
    Cond = 4'b1111; #1;
    chk("t4_nv", CondEx, 0);
    MemW = 0; FlagW = 2'b00;

    // 5: full condition x flags sweep
    for (int f = 0; f < 16; f++) begin
      load_flags(4'(f));
      en = 0;
      for (int c = 0; c < 16; c++) begin
        Cond = 4'(c); #1;
        checks++;
        assert (CondEx === ref_cond(4'(c), 4'(f))) else begin
          errors++;
          $error("FAIL sweep c=%0h f=%0h: observed %0b expected %0b",
                 c, f, CondEx, ref_cond(4'(c), 4'(f)));
        end
      end
    end
    // flags now 1111; stalled instruction writes nothing
    en = 0; Cond = 4'b1110; RegW = 1; FlagW = 2'b11; ALUFlags = 4'b0000; #1;
    chk("t5_stall_regwrite", RegWrite, 0);
    chk("t5_stall_condex", CondEx, 1);
    tick();
    chk("t5_stall_flags", Flags, 4'b1111);
    RegW = 0; FlagW = 2'b00;

    // 6: counters
    reset = 1; #1; reset = 0;
    @(posedge clk); #1;
    en = 1; Cond = 4'b1110; FlagW = 2'b11; ALUFlags = 4'b1010;
    repeat (3) tick();
    FlagW = 2'b00; Cond = 4'b1111;
    repeat (2) tick();
    en = 0; Cond = 4'b1110;
    tick();
    exp_e = perf ? 4'd3 : 4'd0;
    exp_s = perf ? 4'd2 : 4'd0;
    chk("t6_exec", ExecCnt, exp_e);
    chk("t6_squash", SquashCnt, exp_s);
    chk("t6_flags_pre", Flags, 4'b1010);
    // asynchronous reset away from any edge
    #2; reset = 1; #1;
    chk("t6_rst_flags", Flags, 4'b0000);
    chk("t6_rst_exec", ExecCnt, 0);
    chk("t6_rst_squash", SquashCnt, 0);
    Cond = 4'b0001; #1;
    chk("t6_rst_ne", CondEx, 1);
    reset = 0;
    @(posedge clk); #1;
    en = 1; Cond = 4'b1110;
    repeat (20) tick();
    exp_e = perf ? 4'd15 : 4'd0;
    chk("t6_sat_exec", ExecCnt, exp_e);
    chk("t6_sat_squash", SquashCnt, 0);
    en = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
